// File: rtl/usbf_wb_master_pkg.sv
// rtl/usbf_wb_master_pkg.sv - shared types and constants for the usbf Wishbone master
package usbf_wb_master_pkg;

  localparam int USBF_UFC_HADR = 17;
  localparam int DMA_STRIDE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic {
    SRC_CPU,
    SRC_DMA
  } src_e;

endpackage

// File: rtl/usbf_rr_arb16.sv
// rtl/usbf_rr_arb16.sv - combinational 16-way round-robin arbiter
// Search starts at last_i + 1 and wraps; last_i itself is considered last.
module usbf_rr_arb16 (
  input  logic [15:0] elig_i,
  input  logic [3:0]  last_i,
  output logic [3:0]  gnt_o,
  output logic        valid_o
);

  logic [3:0] idx;

  // Walk from the farthest offset down so the nearest eligible channel wins.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = 16; off >= 1; off--) begin
      idx = last_i + 4'(off);
      if (elig_i[idx]) begin
        gnt_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usbf_wb_master.sv
// rtl/usbf_wb_master.sv - Wishbone master merging a CPU port and 16 DMA channels
// Single-beat transfers; DMA writes come from wr_* and DMA reads leave on rd_*.
module usbf_wb_master
  import usbf_wb_master_pkg::*;
#(
  parameter int ADDR_W   = USBF_UFC_HADR + 1,
  parameter int DMA_BASE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] wb_addr_i,
  output logic [31:0]       wb_data_i,
  output logic              wb_we_i,
  output logic              wb_stb_i,
  output logic              wb_cyc_i,
  input  logic [31:0]       wb_data_o,
  input  logic              wb_ack_o,
  input  logic [15:0]       dma_req_o,
  output logic [15:0]       dma_ack_i,
  input  logic [15:0]       dma_dir,
  input  logic              susp_o,
  output logic              resume_req_i,
  input  logic              wake,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [31:0]       rd_data,
  output logic [3:0]        rd_chan,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              dma_err
);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [3:0]        chan_q, chan_d;
  logic [3:0]        last_q, last_d;
  logic              cpu_last_q, cpu_last_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [3:0]        rd_chan_q, rd_chan_d;
  logic              rd_valid_q, rd_valid_d;
  logic              resume_q, resume_d;

  logic [15:0]       elig;
  logic [3:0]        arb_gnt;
  logic              arb_valid;
  logic              pick_cpu;
  logic              pick_dma;
  logic [ADDR_W-1:0] dma_addr;

  // A read channel only qualifies if the sink slot will be free by the time data lands.
  always_comb begin
    elig = '0;
    for (int n = 0; n < 16; n++) begin
      elig[n] = dma_req_o[n] & ~susp_o &
                (dma_dir[n] ? (~rd_valid_q | rd_ready) : wr_valid);
    end
  end

  usbf_rr_arb16 u_arb (
    .elig_i  (elig),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign pick_cpu = cpu_req & ~(cpu_last_q & arb_valid);
  assign pick_dma = ~pick_cpu & arb_valid;
  assign dma_addr = ADDR_W'(DMA_BASE + DMA_STRIDE * int'(arb_gnt));
  assign resume_d = susp_o & (resume_q | wake);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    chan_d      = chan_q;
    last_d      = last_q;
    cpu_last_d  = cpu_last_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    rd_data_d   = rd_data_q;
    rd_chan_d   = rd_chan_q;
    rd_valid_d  = rd_valid_q & ~rd_ready;
    wr_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_cpu) begin
          state_d    = ST_BUS;
          src_d      = SRC_CPU;
          cpu_last_d = 1'b1;
          tmo_d      = '0;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          we_d       = cpu_we;
        end else if (pick_dma) begin
          state_d    = ST_BUS;
          src_d      = SRC_DMA;
          chan_d     = arb_gnt;
          last_d     = arb_gnt;
          cpu_last_d = 1'b0;
          tmo_d      = '0;
          addr_d     = dma_addr;
          wdata_d    = wr_data;
          we_d       = ~dma_dir[arb_gnt];
          wr_ready   = ~dma_dir[arb_gnt];
        end
      end
      ST_BUS: begin
        if (wb_ack_o) begin
          state_d = ST_DONE;
          if (src_q == SRC_CPU) begin
            cpu_rdata_d = wb_data_o;
          end else if (!we_q) begin
            rd_data_d  = wb_data_o;
            rd_chan_d  = chan_q;
            rd_valid_d = 1'b1;
          end
        end else if (tmo_q == 8'(TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_CPU;
      chan_q      <= '0;
      last_q      <= 4'hF;
      cpu_last_q  <= 1'b0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      rd_data_q   <= '0;
      rd_chan_q   <= '0;
      rd_valid_q  <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      chan_q      <= chan_d;
      last_q      <= last_d;
      cpu_last_q  <= cpu_last_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      rd_data_q   <= rd_data_d;
      rd_chan_q   <= rd_chan_d;
      rd_valid_q  <= rd_valid_d;
      resume_q    <= resume_d;
    end
  end

  assign wb_cyc_i     = (state_q == ST_BUS);
  assign wb_stb_i     = (state_q == ST_BUS);
  assign wb_addr_i    = addr_q;
  assign wb_data_i    = wdata_q;
  assign wb_we_i      = we_q;
  assign cpu_ack      = ((state_q == ST_DONE) || (state_q == ST_ERR)) && (src_q == SRC_CPU);
  assign cpu_err      = (state_q == ST_ERR) && (src_q == SRC_CPU);
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_ack_i    = ((state_q == ST_DONE) && (src_q == SRC_DMA)) ? (16'd1 << chan_q) : 16'd0;
  assign dma_err      = (state_q == ST_ERR) && (src_q == SRC_DMA);
  assign rd_data      = rd_data_q;
  assign rd_chan      = rd_chan_q;
  assign rd_valid     = rd_valid_q;
  assign resume_req_i = resume_q;

endmodule
